// File: rtl/rx_frame_pkg.sv
// Shared definitions for the command-link receive framer: state encoding,
// framing constants and the LEN legality test also used by the tx-side framer.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        HUNT     = 3'd0,
        GET_LEN  = 3'd1,
        GET_PLD  = 3'd2,
        GET_CRC  = 3'd3,
        WAIT_RES = 3'd4,
        DELIVER  = 3'd5
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF      = 8'hA5;
    localparam int         MAX_PAYLOAD_DEF    = 16;
    localparam int         TIMEOUT_CYCLES_DEF = 50000;
    localparam logic [7:0] LEN_MIN            = 8'd1;

    // LEN is judged on all 8 bits so that e.g. 8'h90 is not mistaken for 16.
    function automatic logic len_legal(input logic [7:0] len, input logic [7:0] max_len);
        return (len >= LEN_MIN) && (len <= max_len);
    endfunction

endpackage

// File: rtl/rx_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, asynchronous read.
module rx_frame_buf #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [7:0]       wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [7:0]       rd_data_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] mem_q [DEPTH];
    logic       unused_hi;

    // Indices never exceed DEPTH-1, so only the low address bits select a row.
    assign unused_hi = ^{wr_idx_i[IDX_W-1:AW], rd_idx_i[IDX_W-1:AW]};

    // Store one payload byte per write strobe.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_idx_i[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i[AW-1:0]];

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: sync hunt, LEN/payload/CRC parsing, CRC checker
// sequencing, inter-byte timeout and gated payload release to the decoder.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int          MAX_PAYLOAD    = MAX_PAYLOAD_DEF,
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic       o_crc_clear,
    output logic       o_crc_valid,
    output logic       o_crc_last,
    output logic [7:0] o_crc_data,
    input  logic       i_crc_done,
    input  logic       i_crc_match,
    output logic [7:0] o_pld_data,
    output logic       o_pld_valid,
    output logic       o_pld_last,
    input  logic       i_pld_ready,
    output logic       o_crc_err,
    output logic       o_len_err,
    output logic       o_timeout,
    output logic       o_overrun
);

    localparam int                IDX_W   = $clog2(MAX_PAYLOAD + 1);
    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]        MAX_LEN = 8'(MAX_PAYLOAD);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    rx_state_e        state_q, state_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] last_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             crc_valid_q, crc_valid_d;
    logic             crc_last_q, crc_last_d;
    logic [7:0]       crc_data_q, crc_data_d;
    logic             overrun_q, overrun_d;
    logic             buf_we;
    logic             byte_taken;
    logic             counting;
    logic             len_err, crc_err, timeout;
    logic [7:0]       rd_data;

    assign last_idx = len_q - IDX_W'(1);

    rx_frame_buf #(
        .DEPTH (MAX_PAYLOAD),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk       (clk),
        .we_i      (buf_we),
        .wr_idx_i  (wr_idx_q),
        .wr_data_i (i_byte),
        .rd_idx_i  (rd_idx_q),
        .rd_data_o (rd_data)
    );

    // Next-state, CRC forwarding, buffer write and error pulse decisions.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        crc_valid_d = 1'b0;
        crc_last_d  = 1'b0;
        crc_data_d  = crc_data_q;
        overrun_d   = overrun_q;
        buf_we      = 1'b0;
        byte_taken  = 1'b0;
        len_err     = 1'b0;
        crc_err     = 1'b0;
        timeout     = 1'b0;
        counting    = (state_q inside {GET_LEN, GET_PLD, GET_CRC, WAIT_RES});

        // An expiring timer wins over a byte landing in the same cycle.
        if (counting && (cnt_q == TO_LAST)) begin
            timeout = 1'b1;
            state_d = HUNT;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (i_byte_valid && (i_byte == SYNC_BYTE)) begin
                        state_d = GET_LEN;
                    end
                end
                GET_LEN: begin
                    if (i_byte_valid) begin
                        byte_taken = 1'b1;
                        if (len_legal(i_byte, MAX_LEN)) begin
                            crc_valid_d = 1'b1;
                            crc_data_d  = i_byte;
                            len_d       = i_byte[IDX_W-1:0];
                            wr_idx_d    = '0;
                            state_d     = GET_PLD;
                        end else begin
                            len_err = 1'b1;
                            state_d = HUNT;
                        end
                    end
                end
                GET_PLD: begin
                    if (i_byte_valid) begin
                        byte_taken  = 1'b1;
                        crc_valid_d = 1'b1;
                        crc_data_d  = i_byte;
                        buf_we      = 1'b1;
                        wr_idx_d    = wr_idx_q + IDX_W'(1);
                        if (wr_idx_q == last_idx) begin
                            state_d = GET_CRC;
                        end
                    end
                end
                GET_CRC: begin
                    if (i_byte_valid) begin
                        byte_taken  = 1'b1;
                        crc_valid_d = 1'b1;
                        crc_last_d  = 1'b1;
                        crc_data_d  = i_byte;
                        state_d     = WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    // The first WAIT_RES cycle carries the last-byte strobe; the
                    // checker cannot have a result for this frame yet.
                    if (i_crc_done && !crc_valid_q) begin
                        if (i_crc_match) begin
                            rd_idx_d = '0;
                            state_d  = DELIVER;
                        end else begin
                            crc_err = 1'b1;
                            state_d = HUNT;
                        end
                    end
                end
                DELIVER: begin
                    if (i_byte_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (i_pld_ready) begin
                        if (rd_idx_q == last_idx) begin
                            state_d = HUNT;
                        end else begin
                            rd_idx_d = rd_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (!counting || byte_taken || (state_d != state_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, indices, timer and registered CRC forward path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HUNT;
            len_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            cnt_q       <= '0;
            crc_valid_q <= 1'b0;
            crc_last_q  <= 1'b0;
            crc_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            cnt_q       <= cnt_d;
            crc_valid_q <= crc_valid_d;
            crc_last_q  <= crc_last_d;
            crc_data_q  <= crc_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_crc_clear = (state_q == HUNT);
    assign o_crc_valid = crc_valid_q;
    assign o_crc_last  = crc_last_q;
    assign o_crc_data  = crc_data_q;
    assign o_pld_valid = (state_q == DELIVER) && !reset;
    assign o_pld_last  = o_pld_valid && (rd_idx_q == last_idx);
    assign o_pld_data  = o_pld_valid ? rd_data : 8'h00;
    assign o_crc_err   = crc_err && !reset;
    assign o_len_err   = len_err && !reset;
    assign o_timeout   = timeout && !reset;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with a behavioural CRC8 checker and a
// payload scoreboard filled as frames are driven.
module tb_rx_frame_ctrl;

    localparam int         TO   = 50000;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk;
    logic       reset;
    logic [7:0] i_byte;
    logic       i_byte_valid;
    logic       o_crc_clear, o_crc_valid, o_crc_last;
    logic [7:0] o_crc_data;
    logic       i_crc_done, i_crc_match;
    logic [7:0] o_pld_data;
    logic       o_pld_valid, o_pld_last;
    logic       i_pld_ready;
    logic       o_crc_err, o_len_err, o_timeout, o_overrun;

    rx_frame_ctrl #(
        .SYNC_BYTE      (SYNC),
        .MAX_PAYLOAD    (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_crc_clear  (o_crc_clear),
        .o_crc_valid  (o_crc_valid),
        .o_crc_last   (o_crc_last),
        .o_crc_data   (o_crc_data),
        .i_crc_done   (i_crc_done),
        .i_crc_match  (i_crc_match),
        .o_pld_data   (o_pld_data),
        .o_pld_valid  (o_pld_valid),
        .o_pld_last   (o_pld_last),
        .i_pld_ready  (i_pld_ready),
        .o_crc_err    (o_crc_err),
        .o_len_err    (o_len_err),
        .o_timeout    (o_timeout),
        .o_overrun    (o_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reflected CRC8, poly 0xC6; appending the running value zeroes it.
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 8'hC6) : (r >> 1);
        end
        return r;
    endfunction

    // External CRC checker: cleared by o_crc_clear, done one cycle after the last byte.
    logic [7:0] chk_crc;
    logic       chk_done, chk_match;
    always @(posedge clk) begin
        if (o_crc_clear === 1'b1) begin
            chk_crc   <= 8'h0D;
            chk_done  <= 1'b0;
            chk_match <= 1'b0;
        end else if (o_crc_valid === 1'b1) begin
            chk_crc <= crc8(chk_crc, o_crc_data);
            if (o_crc_last) begin
                chk_done  <= 1'b1;
                chk_match <= (crc8(chk_crc, o_crc_data) == 8'h00);
            end
        end
    end
    assign i_crc_done  = chk_done;
    assign i_crc_match = chk_match;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_crcv = 0, n_pldv = 0, n_len = 0, n_crcerr = 0, n_to = 0;
    int s_crcv, s_pldv, s_len, s_crcerr, s_to;
    int to_cyc = -10;
    int strobe_cyc = 0;
    logic clr_after_to = 1'b0;
    logic [8:0] exp_q [$];
    logic [7:0] pb [$];
    logic [7:0] bad_len [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Per-cycle observation, sampled on the falling edge.
    task automatic mon();
        logic [8:0] e;
        cyc++;
        if (!reset) begin
            if (o_crc_valid) n_crcv++;
            if (o_len_err)   n_len++;
            if (o_crc_err)   n_crcerr++;
            if (o_timeout) begin
                n_to++;
                to_cyc = cyc;
            end
            if (to_cyc == cyc - 1) clr_after_to = o_crc_clear;
            if (i_byte_valid) strobe_cyc = cyc;
            if (o_pld_valid) begin
                n_pldv++;
                if (i_pld_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pld_unexpected", 32'(o_pld_data), 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pld_data", 32'(o_pld_data), 32'(e[7:0]));
                        chk("pld_last", 32'(o_pld_last), 32'(e[8]));
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_crcv = n_crcv; s_pldv = n_pldv; s_len = n_len; s_crcerr = n_crcerr; s_to = n_to;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        step();
        i_byte_valid = 1'b0;
        repeat (3) step();
    endtask

    // Drive SYNC, LEN, pb[] and CRC (xor flip); queue payload if it should come out.
    task automatic send_frame(input logic [7:0] flip, input bit deliver);
        logic [7:0] c;
        logic [7:0] len;
        len = 8'(pb.size());
        c   = crc8(8'h0D, len);
        send_byte(SYNC);
        send_byte(len);
        foreach (pb[i]) begin
            c = crc8(c, pb[i]);
            if (deliver) exp_q.push_back({(i == pb.size() - 1), pb[i]});
            send_byte(pb[i]);
        end
        send_byte(c ^ flip);
    endtask

    initial begin
        reset        = 1'b1;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        i_pld_ready  = 1'b1;
        bad_len[0] = 8'h00; bad_len[1] = 8'h11; bad_len[2] = 8'h90;
        repeat (3) step();

        chk("rst_crc_clear", 32'(o_crc_clear), 32'd1);
        chk("rst_crc_valid", 32'(o_crc_valid), 32'd0);
        chk("rst_crc_last",  32'(o_crc_last),  32'd0);
        chk("rst_crc_data",  32'(o_crc_data),  32'd0);
        chk("rst_pld_valid", 32'(o_pld_valid), 32'd0);
        chk("rst_pld_last",  32'(o_pld_last),  32'd0);
        chk("rst_pld_data",  32'(o_pld_data),  32'd0);
        chk("rst_errs", 32'({o_crc_err, o_len_err, o_timeout, o_overrun}), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // Good frame
        pb = '{8'h11, 8'h22, 8'h33};
        snap();
        send_frame(8'h00, 1'b1);
        repeat (20) step();
        chk("good_drain", 32'(exp_q.size()), 32'd0);
        chk("good_pldv",  32'(n_pldv - s_pldv), 32'd3);
        chk("good_crcv",  32'(n_crcv - s_crcv), 32'd5);
        chk("good_errs",  32'((n_crcerr - s_crcerr) + (n_len - s_len) + (n_to - s_to)), 32'd0);
        chk("good_hunt",  32'(o_crc_clear), 32'd1);

        // Corrupted CRC, then a good frame
        snap();
        send_frame(8'h01, 1'b0);
        repeat (20) step();
        chk("bad_crcerr", 32'(n_crcerr - s_crcerr), 32'd1);
        chk("bad_pldv",   32'(n_pldv - s_pldv), 32'd0);
        chk("bad_crcv",   32'(n_crcv - s_crcv), 32'd5);
        pb = '{8'h01, 8'h02, 8'h03, 8'h04};
        snap();
        send_frame(8'h00, 1'b1);
        repeat (20) step();
        chk("after_bad_drain",  32'(exp_q.size()), 32'd0);
        chk("after_bad_pldv",   32'(n_pldv - s_pldv), 32'd4);
        chk("after_bad_crcerr", 32'(n_crcerr - s_crcerr), 32'd0);

        // Illegal LEN values
        for (int j = 0; j < 3; j++) begin
            snap();
            send_byte(SYNC);
            send_byte(bad_len[j]);
            repeat (5) step();
            chk("len_err_pulse", 32'(n_len - s_len), 32'd1);
            chk("len_no_crcv",   32'(n_crcv - s_crcv), 32'd0);
            chk("len_hunt",      32'(o_crc_clear), 32'd1);
        end

        // Maximum legal LEN
        pb.delete();
        for (int j = 0; j < 16; j++) pb.push_back(8'(j * 7 + 1));
        snap();
        send_frame(8'h00, 1'b1);
        repeat (40) step();
        chk("max_drain", 32'(exp_q.size()), 32'd0);
        chk("max_pldv",  32'(n_pldv - s_pldv), 32'd16);
        chk("max_len",   32'(n_len - s_len), 32'd0);

        // Timeout after A5 02 44
        snap();
        send_byte(SYNC);
        send_byte(8'h02);
        i_byte       = 8'h44;
        i_byte_valid = 1'b1;
        step();
        i_byte_valid = 1'b0;
        repeat (TO + 5) step();
        chk("to_pulses",    32'(n_to - s_to), 32'd1);
        chk("to_cycle",     32'(to_cyc - strobe_cyc), 32'(TO));
        chk("to_clear_nxt", 32'(clr_after_to), 32'd1);
        chk("to_pldv",      32'(n_pldv - s_pldv), 32'd0);

        // Reset in the middle of a frame
        send_byte(SYNC);
        send_byte(8'h03);
        send_byte(8'h11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        snap();
        chk("mid_rst_hunt", 32'(o_crc_clear), 32'd1);
        repeat (20) step();
        chk("mid_rst_quiet", 32'((n_pldv - s_pldv) + (n_len - s_len) + (n_crcerr - s_crcerr) + (n_to - s_to)), 32'd0);

        // Decoder stalls while another byte arrives
        i_pld_ready = 1'b0;
        pb = '{8'hC1, 8'hC2, 8'hC3};
        send_frame(8'h00, 1'b1);
        repeat (5) step();
        chk("stall_valid", 32'(o_pld_valid), 32'd1);
        chk("stall_data",  32'(o_pld_data), 32'hC1);
        chk("stall_last",  32'(o_pld_last), 32'd0);
        chk("ovr_before",  32'(o_overrun), 32'd0);
        send_byte(SYNC);
        chk("ovr_set", 32'(o_overrun), 32'd1);
        repeat (90) step();
        chk("stall_hold", 32'(o_pld_valid), 32'd1);
        i_pld_ready = 1'b1;
        repeat (10) step();
        chk("ovr_drain",  32'(exp_q.size()), 32'd0);
        chk("ovr_sticky", 32'(o_overrun), 32'd1);
        chk("ovr_hunt",   32'(o_crc_clear), 32'd1);

        // Noise before sync and a sync value inside the payload
        snap();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        chk("noise_hunt", 32'(o_crc_clear), 32'd1);
        pb = '{8'hA5, 8'h7E};
        send_frame(8'h00, 1'b1);
        repeat (20) step();
        chk("noise_drain", 32'(exp_q.size()), 32'd0);
        chk("noise_pldv",  32'(n_pldv - s_pldv), 32'd2);
        chk("noise_errs",  32'((n_crcerr - s_crcerr) + (n_len - s_len)), 32'd0);
        chk("noise_crcv",  32'(n_crcv - s_crcv), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Receive-side frame controller for the Sigma Delta DAQ command link. It hunts for a sync byte in the UART byte stream, parses a length-prefixed frame and sequences the external CRC8 checker over LEN, payload and CRC bytes. It buffers the payload and releases it to the command decoder only after a CRC match. It sits between the UART receiver and the command decoder, and restarts the CRC checker between frames through its clear line.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker (not fed to CRC)
- MAX_PAYLOAD, 16, payload buffer depth in bytes (LEN legal range 1..MAX_PAYLOAD)
- TIMEOUT_CYCLES, 50000, max clk cycles between bytes inside a frame, and max wait for CRC result
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_byte  in  8  received byte from UART
- i_byte_valid  in  1  one-cycle strobe; UART guarantees ≥2 idle cycles between strobes
- o_crc_clear  out  1  restart of CRC checker (drives its reset)
- o_crc_valid  out  1  byte strobe to CRC checker
- o_crc_last  out  1  marks CRC byte
- o_crc_data  out  8  byte to CRC checker
- i_crc_done  in  1  CRC checker result ready (level, sticky until clear)
- i_crc_match  in  1  CRC remainder == 0, qualified by i_crc_done
- o_pld_data  out  8  payload byte to decoder
- o_pld_valid  out  1  payload byte available
- o_pld_last  out  1  final payload byte of frame
- i_pld_ready  in  1  decoder accepts byte (valid && ready = transfer)
- o_crc_err  out  1  one-cycle pulse: frame rejected on CRC mismatch
- o_len_err  out  1  one-cycle pulse: LEN == 0 or LEN > MAX_PAYLOAD
- o_timeout  out  1  one-cycle pulse: frame aborted on timeout
- o_overrun  out  1  sticky; byte arrived during DELIVER; cleared by reset only

## Operation
- States: HUNT, GET_LEN, GET_PLD, GET_CRC, WAIT_RES, DELIVER.
- HUNT: o_crc_clear=1. On i_byte_valid && i_byte==SYNC_BYTE, go to GET_LEN. o_crc_clear drops on the next cycle. Other bytes are ignored.
- GET_LEN: the byte is forwarded to CRC. If LEN is legal, latch it, set wr_idx=0 and go to GET_PLD. If illegal, pulse o_len_err and go to HUNT; the byte is not forwarded.
- GET_PLD: each byte is forwarded to CRC and written to buf[wr_idx], and wr_idx is incremented. When wr_idx reaches LEN-1 with a byte accepted, go to GET_CRC.
- GET_CRC: the byte is forwarded with o_crc_last=1, then go to WAIT_RES.
- WAIT_RES: on i_crc_done, if i_crc_match go to DELIVER with rd_idx=0. Otherwise pulse o_crc_err and go to HUNT.
- DELIVER: o_pld_data=buf[rd_idx] and o_pld_valid=1. o_pld_last=1 when rd_idx==LEN-1. On transfer, rd_idx is incremented. After the transfer of the last byte, go to HUNT.
- A byte arriving in DELIVER sets o_overrun and is dropped; it is not parsed for sync.
- Timeout: a counter reloads on every accepted byte and on each state entry. It runs in GET_LEN, GET_PLD, GET_CRC and WAIT_RES. When it reaches TIMEOUT_CYCLES-1, pulse o_timeout and go to HUNT. Timeout takes priority over a byte arriving in the same cycle. The counter never runs in HUNT or DELIVER.
- A SYNC_BYTE value inside a frame is data; no resync mid-frame.
- Index widths: $clog2(MAX_PAYLOAD+1) bits. LEN compare is on the full 8-bit LEN.

## Timing
- Reset values: state=HUNT, o_crc_clear=1, all other outputs 0, buf contents don't-care.
- The CRC forward path is registered: o_crc_valid/o_crc_data/o_crc_last assert one cycle after the i_byte_valid that produced them, for exactly one cycle.
- Clear-to-first-byte: o_crc_clear is low at least 2 cycles before the first o_crc_valid (the UART spacing guarantees this; the checker needs 1 cycle to leave its idle state).
- WAIT_RES samples i_crc_done from the cycle after the o_crc_last strobe. The checker asserts done 1 cycle after consuming the last byte.
- The decoder may hold i_pld_ready low indefinitely; DELIVER has no timeout.
- Back-to-back frames: after the last transfer, HUNT is entered on the next edge and re-asserts o_crc_clear.
- Reset mid-frame: returns to HUNT next edge with no error pulses and no payload output.

## Structure
- Package rx_frame_pkg: state enum (3-bit), SYNC_BYTE default, LEN-error and timeout constants shared with the tx-side framer.
- One natural sub-module: rx_frame_buf, the MAX_PAYLOAD×8 register array with write port (we, wr_idx, data) and async read port (rd_idx). The FSM, counters and CRC sequencing stay in rx_frame_ctrl.

## Test plan
- Good frame A5 03 11 22 33 <crc>, with the CRC from the model (reflected poly 0xC6, init 0x0D, remainder 0) -> payload 11, 22, 33 out, o_pld_last on 33, no error pulses.
- Same frame with the CRC byte XOR 0x01 -> o_crc_err pulses once, o_pld_valid never asserts, then a following good frame is delivered.
- A5 00 and A5 11 (LEN 17 > 16) -> o_len_err pulse each, o_crc_valid never asserts for the LEN byte, back to HUNT.
- A5 02 44, then silence for TIMEOUT_CYCLES -> o_timeout pulses exactly once at the cycle-exact point, and o_crc_clear is high the next cycle.
- Good frame with i_pld_ready low for 100 cycles while a byte arrives -> o_overrun sets and stays set, payload is still delivered intact.
- Noise 00 FF 5A before A5 and a payload containing A5 -> noise is ignored and the A5 inside the payload is delivered as data.
